seg_scanner: RTL and testbench

Time-multiplexed driver for the board's 5-digit common-anode seven-segment display. It consumes the 20-bit `disp` bus produced by the top-level mode manager as five 4-bit hex nibbles. It latches that bus once per frame for tear-free updates, then scans the digits one at a time with optional anti-ghosting dead time between them. It sits between the manager and the board pins, alongside the LED twinkle driver.

---
 rtl/seg_scanner_if.sv | 19 +
 rtl/seg_scanner.sv | 133 +++++++++++++
 tb/tb_seg_scanner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_scanner_if.sv
// -----------------------------------------------------------------------------
// seg_scanner_if
//   Bundle between the mode manager and the seven-segment scanner.
//   disp       : 20-bit display data, five hex nibbles, nibble 0 = rightmost digit
//   an         : anode enables, active low, one bit per digit
//   seg        : segments {g,f,e,d,c,b,a}, active low
//   frame_tick : one-cycle pulse at the first output cycle of each frame
//   master : producer of disp / consumer of the pin-side outputs
//   slave  : the scanner itself
// -----------------------------------------------------------------------------
interface seg_scanner_if;
    logic [19:0] disp;
    logic [4:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    modport master (output disp, input an, input seg, input frame_tick);
    modport slave  (input disp, output an, output seg, output frame_tick);
endinterface

// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
//   Time-multiplexed driver for a 5-digit common-anode seven-segment display.
//   The disp bus is latched into a shadow register once per frame (at the last
//   cycle of digit 4) so a frame never shows a mix of old and new data. Digits
//   are scanned 0..4, each for CLK_DIV cycles.
//
//   Optional feature macro: SCAN_DEADTIME_EN
//     defined   : each digit slot starts with DEAD blanked cycles (anti-ghosting)
//     undefined : the digit is lit for the whole slot, DEAD is ignored
//
//   Parameters:
//     CLK_DIV : cycles per digit slot (>= 2)
//     DEAD    : blank cycles at slot start (1 <= DEAD < CLK_DIV)
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : seg_scanner_if.slave (disp in; an, seg, frame_tick out)
//
//   an/seg/frame_tick are registered: the output in cycle t+1 reflects the
//   slot counter, digit index and shadow register during cycle t.
// -----------------------------------------------------------------------------
module seg_scanner #(
    parameter int CLK_DIV = 20000,
    parameter int DEAD    = 2000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scanner_if.slave  bus
);

    localparam int          CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("seg_scanner: CLK_DIV must be >= 2");
    end
    if (DEAD < 1 || DEAD >= CLK_DIV) begin : g_bad_dead
        $error("seg_scanner: DEAD must satisfy 1 <= DEAD < CLK_DIV");
    end

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_dig;
    logic [19:0]   r_shd;

    logic [4:0]    r_an_p1;
    logic [6:0]    r_seg_p1;
    logic          r_tick_p1;

    logic          w_slot_end;
    logic          w_lit;
    logic [3:0]    w_nib;

    assign w_slot_end = (r_cnt == LAST);
    assign w_nib      = 4'(r_shd >> {r_dig, 2'b00});

    always_comb begin
        w_lit = 1'b1;
`ifdef SCAN_DEADTIME_EN
        w_lit = (r_cnt >= CW'(DEAD));
`endif
    end

    // Stage p0: slot counter, digit index and frame shadow latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dig <= '0;
            r_shd <= '0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_dig <= (r_dig == 3'd4) ? 3'd0 : r_dig + 3'd1;
                // Latch on the very last cycle of the frame so the new data
                // takes effect exactly at digit 0 of the next frame.
                if (r_dig == 3'd4) begin
                    r_shd <= bus.disp;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Stage p1: registered pin drive. an and seg switch on the same edge, so
    // an is never low while seg changes; the dead-time gap covers slot moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_p1   <= 5'b11111;
            r_seg_p1  <= 7'b1111111;
            r_tick_p1 <= 1'b0;
        end else begin
            r_tick_p1 <= (r_cnt == '0) && (r_dig == 3'd0);
            if (w_lit) begin
                r_an_p1  <= ~(5'b00001 << r_dig);
                r_seg_p1 <= hex_decode(w_nib);
            end else begin
                r_an_p1  <= 5'b11111;
                r_seg_p1 <= 7'b1111111;
            end
        end
    end

    assign bus.an         = r_an_p1;
    assign bus.seg        = r_seg_p1;
    assign bus.frame_tick = r_tick_p1;

endmodule

// File: tb/tb_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_scanner
//   Directed bench for seg_scanner with CLK_DIV=4, DEAD=1. Works with the
//   SCAN_DEADTIME_EN macro either defined or undefined.
// -----------------------------------------------------------------------------
module tb_seg_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEAD    = 1;
`ifdef SCAN_DEADTIME_EN
    localparam int DEAD_EFF = DEAD;
`else
    localparam int DEAD_EFF = 0;
`endif

    // Hand-written glyph constants, {g,f,e,d,c,b,a} active low.
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BLANK_SEG = 7'b1111111;
    localparam logic [4:0] BLANK_AN  = 5'b11111;

    // Expected glyph sets, packed {d4,d3,d2,d1,d0}.
    localparam logic [34:0] FR_ZERO  = {G0, G0, G0, G0, G0};
    localparam logic [34:0] FR_12345 = {G1, G2, G3, G4, G5};
    localparam logic [34:0] FR_8F000 = {G8, GF, G0, G0, G0};
    localparam logic [34:0] FR_00004 = {G0, G0, G0, G0, G4};

    // Anode pattern for digits 4..0, packed {d4,...,d0}.
    localparam logic [24:0] AN_TAB = {5'b01111, 5'b10111, 5'b11011, 5'b11101, 5'b11110};

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seg_scanner_if bus ();

    seg_scanner #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_an,
                             input logic [6:0] e_seg, input logic e_tick);
        checks++;
        assert (bus.an === e_an) else begin
            failures++;
            $error("FAIL %s an got=%b exp=%b", tag, bus.an, e_an);
        end
        checks++;
        assert (bus.seg === e_seg) else begin
            failures++;
            $error("FAIL %s seg got=%b exp=%b", tag, bus.seg, e_seg);
        end
        checks++;
        assert (bus.frame_tick === e_tick) else begin
            failures++;
            $error("FAIL %s frame_tick got=%b exp=%b", tag, bus.frame_tick, e_tick);
        end
    endtask

    // Advance and check output cycles k_from..k_to-1 of a frame.
    task automatic run_cycles(input string name, input logic [34:0] glyphs,
                              input int k_from, input int k_to);
        logic [34:0] gl;
        logic [24:0] at;
        logic [4:0]  e_an;
        logic [6:0]  e_seg;
        int d, j;
        gl = glyphs;
        at = AN_TAB;
        for (int k = k_from; k < k_to; k++) begin
            step();
            d = k / CLK_DIV;
            j = k % CLK_DIV;
            if (j < DEAD_EFF) begin
                e_an  = BLANK_AN;
                e_seg = BLANK_SEG;
            end else begin
                e_an  = at[d*5 +: 5];
                e_seg = gl[d*7 +: 7];
            end
            check_out($sformatf("%s k%0d", name, k), e_an, e_seg, (k == 0));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.disp = 20'h00000;

        // Reset held: everything blank, no tick.
        for (int i = 0; i < 10; i++) begin
            step();
            check_out($sformatf("reset c%0d", i), BLANK_AN, BLANK_SEG, 1'b0);
        end

        // Release; shadow still zero for the first frame.
        bus.disp = 20'h12345;
        rst_n    = 1'b1;
        run_cycles("frame1", FR_ZERO, 0, 20);

        // Second frame shows 12345; disp changes mid-frame without tearing.
        run_cycles("frame2a", FR_12345, 0, 8);
        bus.disp = 20'h8F000;
        run_cycles("frame2b", FR_12345, 8, 20);

        // New data appears from the next frame on.
        run_cycles("frame3", FR_8F000, 0, 20);

        // Into digit 2 lit phase, then asynchronous reset between edges.
        run_cycles("frame4", FR_8F000, 0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", BLANK_AN, BLANK_SEG, 1'b0);
        step();
        check_out("reset_hold", BLANK_AN, BLANK_SEG, 1'b0);
        bus.disp = 20'h00004;
        rst_n    = 1'b1;

        // Restart from digit 0 with a cleared shadow, then show 00004.
        run_cycles("restart", FR_ZERO, 0, 20);
        run_cycles("frame_4", FR_00004, 0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
